zero_count_arbiter: RTL

ZERO_COUNT_ARBITER -- requirements
Module: zero_count_arbiter

---
 rtl/zero_count_pkg.sv | 12 +
 rtl/zero_count_arbiter_if.sv | 28 ++
 rtl/serial_zero_counter.sv | 53 +++++
 rtl/zero_count_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/zero_count_pkg.sv
// Shared constants and FSM encoding for the zero-count arbiter.
package zero_count_pkg;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_DONE
  } state_e;
endpackage

// File: rtl/zero_count_arbiter_if.sv
// Requester-side bus of the zero-count arbiter: level requests in, one-hot ack and result out.
interface zero_count_arbiter_if
  import zero_count_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       ack;
  logic                  result_valid;
  logic [CW-1:0]         result_count;
  logic [IW-1:0]         result_id;
  logic                  busy;

  modport master (
    output req, data,
    input  ack, result_valid, result_count, result_id, busy
  );

  modport slave (
    input  req, data,
    output ack, result_valid, result_count, result_id, busy
  );
endinterface

// File: rtl/serial_zero_counter.sv
// Bit-serial zero counter: after start, examines one bit of a per cycle, LSB first.
// count/done are combinational so the caller can capture the final total on the last bit.
module serial_zero_counter #(
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(WIDTH + 1),
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic [CW-1:0]    count,
  output logic             done
);
  logic            run_q, run_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Running total including the bit under examination this cycle.
  assign count = cnt_q + {{(CW-1){1'b0}}, ~a[idx_q]};
  assign done  = run_q && (idx_q == IDXW'(WIDTH - 1));

  always_comb begin
    run_d = run_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (start) begin
      run_d = 1'b1;
      idx_d = '0;
      cnt_d = '0;
    end else if (run_q) begin
      cnt_d = count;
      if (done) begin
        run_d = 1'b0;
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/zero_count_arbiter.sv
// Round-robin arbiter that serves one requester at a time and reports the
// number of zero bits in its data word, counted bit-serially.
module zero_count_arbiter
  import zero_count_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  zero_count_arbiter_if.slave  zc
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(NREQ);

  state_e                      state_q, state_d;
  logic [IW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]               gnt_q, gnt_d;
  logic [WIDTH-1:0]            word_q, word_d;
  logic [NREQ-1:0]             ack_q, ack_d;
  logic                        result_valid_q, result_valid_d;
  logic [CW-1:0]               result_count_q, result_count_d;
  logic [IW-1:0]               result_id_q, result_id_d;
  logic                        busy_q, busy_d;

  logic [NREQ-1:0][WIDTH-1:0]  data_arr;
  logic [IW-1:0]               pick;
  logic                        any_req;
  logic                        cnt_start, cnt_done;
  logic [CW-1:0]               cnt_count;

  assign data_arr = zc.data;

  // Scan from the farthest slot back toward rr_ptr so the nearest request wins.
  always_comb begin
    int j;
    pick    = '0;
    any_req = 1'b0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr_q) + k) % NREQ;
      if (zc.req[IW'(j)]) begin
        pick    = IW'(j);
        any_req = 1'b1;
      end
    end
  end

  serial_zero_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .start (cnt_start),
    .a     (word_q),
    .count (cnt_count),
    .done  (cnt_done)
  );

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gnt_d          = gnt_q;
    word_d         = word_q;
    ack_d          = '0;
    result_valid_d = 1'b0;
    result_count_d = result_count_q;
    result_id_d    = result_id_q;
    cnt_start      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          word_d  = data_arr[pick];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_start = 1'b1;
        state_d   = S_COUNT;
      end
      S_COUNT: begin
        // Result flops load on the last counted bit so they are live throughout DONE.
        if (cnt_done) begin
          state_d        = S_DONE;
          result_valid_d = 1'b1;
          result_count_d = cnt_count;
          result_id_d    = gnt_q;
          ack_d[gnt_q]   = 1'b1;
        end
      end
      S_DONE: begin
        rr_ptr_d = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      gnt_q          <= '0;
      word_q         <= '0;
      ack_q          <= '0;
      result_valid_q <= 1'b0;
      result_count_q <= '0;
      result_id_q    <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      gnt_q          <= gnt_d;
      word_q         <= word_d;
      ack_q          <= ack_d;
      result_valid_q <= result_valid_d;
      result_count_q <= result_count_d;
      result_id_q    <= result_id_d;
      busy_q         <= busy_d;
    end
  end

  assign zc.ack          = ack_q;
  assign zc.result_valid = result_valid_q;
  assign zc.result_count = result_count_q;
  assign zc.result_id    = result_id_q;
  assign zc.busy         = busy_q;
endmodule
